// File: rtl/mvm_pkg.sv
// Shared types and default widths for the MVM partial-sum requantizer.
// Pure declarations: no logic, no latency, no flow control.
package mvm_pkg;

   localparam int DEF_MAT_W    = 3;
   localparam int DEF_IN_BITS  = 18;
   localparam int DEF_ACC_BITS = 24;
   localparam int DEF_Q_BITS   = 8;

   typedef enum logic [1:0] {
      ACC_IDLE = 2'd0,
      ACC_RUN  = 2'd1,
      DRAIN    = 2'd2
   } acc_state_e;

   // Column index width; a single column still needs one bit.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mvm_psum_quant_if.sv
// Engine-beat input stream and requantized column output stream.
// Valid/ready on both sides; slave is the requantizer, master its environment.
interface mvm_psum_quant_if #(
   parameter int matW   = mvm_pkg::DEF_MAT_W,
   parameter int inBits = mvm_pkg::DEF_IN_BITS,
   parameter int qBits  = mvm_pkg::DEF_Q_BITS
);
   localparam int idx_w = mvm_pkg::idx_bits(matW);

   logic                     y_valid_i;
   logic                     y_ready_o;
   logic [matW*inBits-1:0]   y_i;
   logic                     first_i;
   logic                     last_i;
   logic [4:0]               shift_i;
   logic                     q_valid_o;
   logic                     q_ready_i;
   logic signed [qBits-1:0]  q_data_o;
   logic [idx_w-1:0]         q_idx_o;
   logic                     busy_o;

   modport slave (
      input  y_valid_i, y_i, first_i, last_i, shift_i, q_ready_i,
      output y_ready_o, q_valid_o, q_data_o, q_idx_o, busy_o
   );

   modport master (
      output y_valid_i, y_i, first_i, last_i, shift_i, q_ready_i,
      input  y_ready_o, q_valid_o, q_data_o, q_idx_o, busy_o
   );

endinterface

// File: rtl/mvm_requant.sv
// Combinational round-half-up, arithmetic right shift and saturation of one
// accumulator value to the output width; zero latency, no flow control.
module mvm_requant #(
   parameter int accBits = mvm_pkg::DEF_ACC_BITS,
   parameter int qBits   = mvm_pkg::DEF_Q_BITS
) (
   input  logic signed [accBits-1:0] acc,
   input  logic        [4:0]         shift,
   output logic signed [qBits-1:0]   q
);

   localparam logic signed [accBits:0] q_max = {{(accBits-qBits+2){1'b0}}, {(qBits-1){1'b1}}};
   localparam logic signed [accBits:0] q_min = {{(accBits-qBits+2){1'b1}}, {(qBits-1){1'b0}}};

   logic signed [accBits:0] wide;
   logic signed [accBits:0] rnd;
   logic signed [accBits:0] sum;
   logic signed [accBits:0] shd;

   always_comb begin
      wide = {acc[accBits-1], acc};
      rnd  = '0;
      if (shift != 5'd0) begin
         rnd = (accBits+1)'(1) << (shift - 5'd1);
      end
      sum = wide + rnd;
      shd = sum >>> shift;
      q   = shd[qBits-1:0];
      // Shifting past the accumulator width rounds every value to zero.
      if (int'(shift) > accBits) begin
         q = '0;
      end else if (shd > q_max) begin
         q = q_max[qBits-1:0];
      end else if (shd < q_min) begin
         q = q_min[qBits-1:0];
      end
   end

endmodule

// File: rtl/mvm_psum_quant.sv
// Accumulates saturating per-column partial sums over K-tiles, then drains one
// requantized column per handshake starting the cycle after the last beat; input stalls during drain.
module mvm_psum_quant
   import mvm_pkg::*;
#(
   parameter int matW    = DEF_MAT_W,
   parameter int inBits  = DEF_IN_BITS,
   parameter int accBits = DEF_ACC_BITS,
   parameter int qBits   = DEF_Q_BITS
) (
   input  logic                clk,
   input  logic                nrst,
   mvm_psum_quant_if.slave     bus
);

   localparam int idx_w = idx_bits(matW);
   localparam logic signed [accBits:0] acc_max = {2'b00, {(accBits-1){1'b1}}};
   localparam logic signed [accBits:0] acc_min = {2'b11, {(accBits-1){1'b0}}};

   acc_state_e                state_q;
   acc_state_e                state_d;
   logic signed [accBits-1:0] acc_q   [matW];
   logic signed [accBits-1:0] acc_nxt [matW];
   logic        [4:0]         shift_q;
   logic        [idx_w-1:0]   idx_q;
   logic signed [accBits:0]   y_ext;
   logic signed [accBits:0]   sum;
   logic                      beat;
   logic                      col_hs;
   logic                      last_col;

   assign beat     = bus.y_valid_i && bus.y_ready_o;
   assign col_hs   = bus.q_valid_o && bus.q_ready_i;
   assign last_col = (idx_q == idx_w'(matW - 1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ACC_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACC_IDLE: if (beat) state_d = bus.last_i ? DRAIN : ACC_RUN;
         ACC_RUN:  if (beat && bus.last_i) state_d = DRAIN;
         DRAIN:    if (col_hs && last_col) state_d = ACC_IDLE;
         default:  state_d = ACC_IDLE;
      endcase
   end

   always_comb begin
      bus.y_ready_o = (state_q != DRAIN);
      bus.q_valid_o = (state_q == DRAIN);
      bus.busy_o    = (state_q != ACC_IDLE);
      bus.q_idx_o   = idx_q;
   end

   // One bit of headroom makes the saturation test exact for any single add.
   always_comb begin
      y_ext = '0;
      sum   = '0;
      for (int j = 0; j < matW; j++) begin
         y_ext = {{(accBits+1-inBits){bus.y_i[j*inBits+inBits-1]}}, bus.y_i[j*inBits +: inBits]};
         sum   = {acc_q[j][accBits-1], acc_q[j]} + y_ext;
         if (bus.first_i) begin
            acc_nxt[j] = y_ext[accBits-1:0];
         end else if (sum > acc_max) begin
            acc_nxt[j] = acc_max[accBits-1:0];
         end else if (sum < acc_min) begin
            acc_nxt[j] = acc_min[accBits-1:0];
         end else begin
            acc_nxt[j] = sum[accBits-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int j = 0; j < matW; j++) begin
            acc_q[j] <= '0;
         end
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         if (beat) begin
            for (int j = 0; j < matW; j++) begin
               acc_q[j] <= acc_nxt[j];
            end
            if (bus.last_i) begin
               shift_q <= bus.shift_i;
            end
         end
         if (col_hs) begin
            idx_q <= last_col ? '0 : idx_q + idx_w'(1);
         end
      end
   end

   mvm_requant #(
      .accBits (accBits),
      .qBits   (qBits)
   ) u_requant (
      .acc   (acc_q[idx_q]),
      .shift (shift_q),
      .q     (bus.q_data_o)
   );

endmodule

// File: tb/tb_mvm_psum_quant.sv
// Directed bench for mvm_psum_quant: hand-computed column values per scenario.
module tb_mvm_psum_quant;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mvm_psum_quant_if bus ();

   mvm_psum_quant dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after an edge with the block ready; returns likewise.
   task automatic send_beat(input int a0, input int a1, input int a2,
                            input logic first, input logic last, input int sh);
      logic [17:0] t0, t1, t2;
      t0 = a0[17:0];
      t1 = a1[17:0];
      t2 = a2[17:0];
      bus.y_i       = {t2, t1, t0};
      bus.first_i   = first;
      bus.last_i    = last;
      bus.shift_i   = sh[4:0];
      bus.y_valid_i = 1'b1;
      step();
      bus.y_valid_i = 1'b0;
      bus.first_i   = 1'b0;
      bus.last_i    = 1'b0;
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.q_valid_o !== 1'b0 || bus.q_idx_o !== 2'd0 || bus.q_data_o !== 8'sd0) begin
         fails++;
         $display("FAIL reset_outputs valid=%b idx=%0d data=%0d required 0/0/0",
                  bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o));
      end
      tests++;
      if (bus.busy_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy got=%b required=0", bus.busy_o);
      end
      nrst = 1'b1;
      step();
      tests++;
      if (bus.y_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.q_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_release ready=%b busy=%b valid=%b required 1/0/0",
                  bus.y_ready_o, bus.busy_o, bus.q_valid_o);
      end
   endtask

   task automatic test_single_tile;
      int want[3] = '{25, -25, 75};
      send_beat(100, -100, 300, 1'b1, 1'b1, 2);
      for (int j = 0; j < 3; j++) begin
         tests++;
         if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'(j) || bus.q_data_o !== 8'(want[j])
             || bus.y_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            fails++;
            $display("FAIL single_col%0d valid=%b idx=%0d data=%0d ready=%b busy=%b required 1/%0d/%0d/0/1",
                     j, bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o), bus.y_ready_o, bus.busy_o, j, want[j]);
         end
         step();
      end
      tests++;
      if (bus.q_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.y_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL single_idle valid=%b busy=%b ready=%b required 0/0/1",
                  bus.q_valid_o, bus.busy_o, bus.y_ready_o);
      end
   endtask

   task automatic test_three_tiles;
      send_beat(50, 50, 50, 1'b1, 1'b0, 0);
      tests++;
      if (bus.busy_o !== 1'b1 || bus.y_ready_o !== 1'b1 || bus.q_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL three_run busy=%b ready=%b valid=%b required 1/1/0",
                  bus.busy_o, bus.y_ready_o, bus.q_valid_o);
      end
      send_beat(50, 50, 50, 1'b0, 1'b0, 0);
      send_beat(50, 50, 50, 1'b0, 1'b1, 0);
      for (int j = 0; j < 3; j++) begin
         tests++;
         if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'(j) || bus.q_data_o !== 8'sd127
             || bus.y_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL three_col%0d valid=%b idx=%0d data=%0d ready=%b required 1/%0d/127/0",
                     j, bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o), bus.y_ready_o, j);
         end
         step();
      end
      tests++;
      if (bus.q_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         fails++;
         $display("FAIL three_idle valid=%b busy=%b required 0/0", bus.q_valid_o, bus.busy_o);
      end
   endtask

   task automatic test_rounding;
      int want[3] = '{2, -1, 1};
      int more[3] = '{7, -5, 6};
      send_beat(6, -6, 5, 1'b1, 1'b1, 2);
      for (int j = 0; j < 3; j++) begin
         tests++;
         if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'(j) || bus.q_data_o !== 8'(want[j])) begin
            fails++;
            $display("FAIL round_col%0d valid=%b idx=%0d data=%0d required 1/%0d/%0d",
                     j, bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o), j, want[j]);
         end
         step();
      end
      // Idle beat without first_i adds onto {6,-6,5} left in the accumulators.
      send_beat(1, 1, 1, 1'b0, 1'b1, 0);
      for (int j = 0; j < 3; j++) begin
         tests++;
         if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'(j) || bus.q_data_o !== 8'(more[j])) begin
            fails++;
            $display("FAIL idle_accum_col%0d valid=%b idx=%0d data=%0d required 1/%0d/%0d",
                     j, bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o), j, more[j]);
         end
         step();
      end
   endtask

   task automatic test_backpressure;
      send_beat(10, 20, 30, 1'b1, 1'b1, 0);
      tests++;
      if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'd0 || bus.q_data_o !== 8'sd10) begin
         fails++;
         $display("FAIL bp_col0 valid=%b idx=%0d data=%0d required 1/0/10",
                  bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o));
      end
      step();
      bus.q_ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tests++;
         if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'd1 || bus.q_data_o !== 8'sd20) begin
            fails++;
            $display("FAIL bp_hold%0d valid=%b idx=%0d data=%0d required 1/1/20",
                     c, bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o));
         end
         if (c < 4) step();
      end
      bus.q_ready_i = 1'b1;
      step();
      tests++;
      if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'd2 || bus.q_data_o !== 8'sd30) begin
         fails++;
         $display("FAIL bp_col2 valid=%b idx=%0d data=%0d required 1/2/30",
                  bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o));
      end
      step();
      tests++;
      if (bus.q_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         fails++;
         $display("FAIL bp_idle valid=%b busy=%b required 0/0", bus.q_valid_o, bus.busy_o);
      end
   endtask

   task automatic test_acc_sat;
      int want[3] = '{127, -128, 0};
      // 70 beats overflow 24 bits; clamped sums become +8388607 / -8388608.
      for (int i = 0; i < 70; i++) begin
         send_beat(131071, -131072, 0, (i == 0), (i == 69), 16);
      end
      for (int j = 0; j < 3; j++) begin
         tests++;
         if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'(j) || bus.q_data_o !== 8'(want[j])) begin
            fails++;
            $display("FAIL accsat_col%0d valid=%b idx=%0d data=%0d required 1/%0d/%0d",
                     j, bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o), j, want[j]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_drain;
      int want[3] = '{5, -1, 0};
      send_beat(100, -100, 300, 1'b1, 1'b1, 2);
      step();
      nrst = 1'b0;
      #1;
      tests++;
      if (bus.q_valid_o !== 1'b0 || bus.q_idx_o !== 2'd0 || bus.q_data_o !== 8'sd0
          || bus.busy_o !== 1'b0 || bus.y_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL midreset_outputs valid=%b idx=%0d data=%0d busy=%b ready=%b required 0/0/0/0/1",
                  bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o), bus.busy_o, bus.y_ready_o);
      end
      @(negedge clk);
      nrst = 1'b1;
      step();
      step();
      tests++;
      if (bus.q_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         fails++;
         $display("FAIL midreset_quiet valid=%b busy=%b required 0/0", bus.q_valid_o, bus.busy_o);
      end
      send_beat(40, -8, 0, 1'b1, 1'b1, 3);
      for (int j = 0; j < 3; j++) begin
         tests++;
         if (bus.q_valid_o !== 1'b1 || bus.q_idx_o !== 2'(j) || bus.q_data_o !== 8'(want[j])) begin
            fails++;
            $display("FAIL midreset_col%0d valid=%b idx=%0d data=%0d required 1/%0d/%0d",
                     j, bus.q_valid_o, bus.q_idx_o, $signed(bus.q_data_o), j, want[j]);
         end
         step();
      end
      tests++;
      if (bus.q_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         fails++;
         $display("FAIL midreset_idle valid=%b busy=%b required 0/0", bus.q_valid_o, bus.busy_o);
      end
   endtask

   initial begin
      bus.y_valid_i = 1'b0;
      bus.y_i       = '0;
      bus.first_i   = 1'b0;
      bus.last_i    = 1'b0;
      bus.shift_i   = '0;
      bus.q_ready_i = 1'b1;
      test_reset();
      test_single_tile();
      test_three_tiles();
      test_rounding();
      test_backpressure();
      test_acc_sat();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mvm_psum_quant.md
MVM_PSUM_QUANT -- requirements
Module: mvm_psum_quant

Interface
REQ-001 Parameter: matW, default 3, number of columns received from mvm_engine per beat.
REQ-002 Parameter: inBits, default 18, signed width of each engine column result (activationBits+matBits+clog2(matH) for 8/8/3).
REQ-003 Parameter: accBits, default 24, signed partial-sum accumulator width per column.
REQ-004 Parameter: qBits, default 8, signed requantized output width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 nrst  input  1  reset, asynchronous, active-low.
REQ-007 y_valid_i  input  1  engine result beat valid.
REQ-008 y_ready_o  output  1  block can accept a beat.
REQ-009 y_i  input  matW x inBits  signed column results, column 0 in lowest slice.
REQ-010 first_i  input  1  beat is first K-tile; qualified by y_valid_i.
REQ-011 last_i  input  1  beat is final K-tile; triggers drain.
REQ-012 shift_i  input  5  arithmetic right-shift amount, sampled on the last beat.
REQ-013 q_valid_o  output  1  requantized column valid.
REQ-014 q_ready_i  input  1  consumer accepts column.
REQ-015 q_data_o  output  qBits  signed requantized column value.
REQ-016 q_idx_o  output  clog2(matW)  column index of q_data_o.
REQ-017 busy_o  output  1  high when state is not ACC_IDLE.

Function
REQ-018 FSM states: ACC_IDLE, ACC_RUN, DRAIN.
REQ-019 Beat accepted when y_valid_i and y_ready_o are both high at a rising edge.
REQ-020 y_ready_o = 1 in ACC_IDLE and ACC_RUN, 0 in DRAIN.
REQ-021 Accepted beat with first_i=1: acc[j] <= sign-extended y_i[j]; otherwise acc[j] <= acc[j] + sign-extended y_i[j].
REQ-022 Accumulation saturates at accBits signed limits (+2^(accBits-1)-1 / -2^(accBits-1)); no wrap.
REQ-023 Beat accepted in ACC_IDLE with first_i=0 is still accumulated onto current acc contents.
REQ-024 Transitions: ACC_IDLE -> ACC_RUN on accepted beat with last_i=0; ACC_IDLE or ACC_RUN -> DRAIN on accepted beat with last_i=1; DRAIN -> ACC_IDLE on handshake of column matW-1.
REQ-025 first_i=1 and last_i=1 on one beat is legal: load then drain.
REQ-026 shift_i latched on last-beat acceptance; held for the whole drain.
REQ-027 Latency: last beat accepted at edge N -> q_valid_o=1, q_idx_o=0 from edge N (visible cycle N+1).
REQ-028 Column j result = saturate_qBits((acc[j] + R) >>> shift), R = 2^(shift-1) if shift>0 else 0; rounding add done at accBits+1 bits, no overflow.
REQ-029 Output saturates to [-2^(qBits-1), 2^(qBits-1)-1].
REQ-030 q_data_o, q_idx_o held stable while q_valid_o=1 and q_ready_i=0.
REQ-031 On column handshake, q_idx_o increments next cycle; after column matW-1, q_valid_o=0 next cycle.
REQ-032 q_valid_o = 0 outside DRAIN; in DRAIN stays 1 until final handshake (no bubbles).
REQ-033 acc contents unchanged during DRAIN.

Reset
REQ-034 nrst low: state=ACC_IDLE, all acc[j]=0, latched shift=0, q_valid_o=0, q_data_o=0, q_idx_o=0, busy_o=0, y_ready_o=1 after release.
REQ-035 Reset mid-drain abandons remaining columns; no output after release until a new last beat.

Structure
REQ-036 Package mvm_pkg holds the FSM state enum and default width constants (matW, inBits, accBits, qBits).
REQ-037 Single sub-module mvm_requant: combinational round, shift, saturate of one accBits value to qBits; instantiated once, fed acc[q_idx].

Verification
REQ-038 Single tile: first=last=1, y_i={100,-100,300}, shift=2 -> columns 25, -25, 75 with idx 0,1,2; then ACC_IDLE.
REQ-039 Three tiles of y_i={50,50,50}, shift=0 -> 127 x3 (150 saturated); y_ready_o low during drain.
REQ-040 Rounding: acc={6,-6,5}, shift=2 -> 2, -1, 1.
REQ-041 Backpressure: q_ready_i low 4 cycles on column 1 -> q_data_o/q_idx_o stable, no column skipped or repeated.
REQ-042 Accumulator saturation: repeated y_i=+131071 beyond 2^23-1 -> acc clamps at 8388607, shift=16 -> 127.
REQ-043 nrst asserted after column 0 handshake -> all outputs reset values; next single-tile beat drains normally from idx 0.
